// File: rtl/param_loader.sv
// Parses framed UART bytes (sync, 18 payload bytes, checksum) into pulse-sequencer
// parameters. The outputs update all at once, and only when a frame's checksum is good.
module param_loader #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hAA,
  parameter int          TIMEOUT_CYC = 500000,
  parameter logic [31:0] DEF_PER     = 32'd4000,
  parameter logic [15:0] DEF_P1      = 16'd30,
  parameter logic [15:0] DEF_DEL     = 16'd200,
  parameter logic [15:0] DEF_P2      = 16'd60,
  parameter logic [7:0]  DEF_NW      = 8'd0,
  parameter logic [15:0] DEF_ND      = 16'd0,
  parameter logic [7:0]  DEF_CP      = 8'd1,
  parameter logic [7:0]  DEF_PBL     = 8'd100,
  parameter logic [15:0] DEF_PBLHF   = 16'd50,
  parameter logic        DEF_BL      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [31:0] per,
  output logic [15:0] p1wid,
  output logic [15:0] del,
  output logic [15:0] p2wid,
  output logic [7:0]  nut_w,
  output logic [15:0] nut_d,
  output logic [7:0]  cp,
  output logic [7:0]  p_bl,
  output logic [15:0] p_bl_hf,
  output logic        bl,
  output logic        rx_done,
  output logic        frame_err,
  output logic        tmo_err,
  output logic        busy
);

  localparam int              CNT_W     = $clog2(TIMEOUT_CYC + 1);
  localparam int              N_PAYLOAD = 18;
  localparam logic [4:0]      LAST_IDX  = 5'd17;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CHECK
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       shadow [N_PAYLOAD];
  logic [4:0]       idx;
  logic [7:0]       sum;
  logic [CNT_W-1:0] tmo_cnt;

  logic start_frame;
  logic store_byte;
  logic commit;
  logic reject;
  logic timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A byte arriving on the cycle the counter would expire wins over the timeout.
  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    store_byte  = 1'b0;
    commit      = 1'b0;
    reject      = 1'b0;
    timeout     = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid && (rx_byte == SYNC_BYTE)) begin
          start_frame = 1'b1;
          state_nxt   = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (rx_valid) begin
          store_byte = 1'b1;
          if (idx == LAST_IDX) state_nxt = CHECK;
        end else if (tmo_cnt == TMO_LAST) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      CHECK: begin
        if (rx_valid) begin
          if (rx_byte == sum) commit = 1'b1;
          else                reject = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx     <= '0;
      sum     <= '0;
      tmo_cnt <= '0;
    end else begin
      if (start_frame) begin
        idx     <= '0;
        sum     <= '0;
        tmo_cnt <= '0;
      end else if (state != IDLE) begin
        tmo_cnt <= rx_valid ? '0 : tmo_cnt + 1'b1;
      end
      if (store_byte) begin
        idx <= idx + 5'd1;
        sum <= sum + rx_byte;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_PAYLOAD; i++) shadow[i] <= '0;
    end else if (store_byte) begin
      shadow[idx] <= rx_byte;
    end
  end

  // Payload fields are big-endian, laid out back to back in the shadow bytes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      per     <= DEF_PER;
      p1wid   <= DEF_P1;
      del     <= DEF_DEL;
      p2wid   <= DEF_P2;
      nut_w   <= DEF_NW;
      nut_d   <= DEF_ND;
      cp      <= DEF_CP;
      p_bl    <= DEF_PBL;
      p_bl_hf <= DEF_PBLHF;
      bl      <= DEF_BL;
    end else if (commit) begin
      per     <= {shadow[0], shadow[1], shadow[2], shadow[3]};
      p1wid   <= {shadow[4], shadow[5]};
      del     <= {shadow[6], shadow[7]};
      p2wid   <= {shadow[8], shadow[9]};
      nut_w   <= shadow[10];
      nut_d   <= {shadow[11], shadow[12]};
      cp      <= shadow[13];
      p_bl    <= shadow[14];
      p_bl_hf <= {shadow[15], shadow[16]};
      bl      <= shadow[17][0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      tmo_err   <= 1'b0;
    end else begin
      rx_done   <= commit;
      frame_err <= reject;
      tmo_err   <= timeout;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_param_loader.sv
// Self-checking bench for param_loader: directed frames from the datasheet plus random
// frames, compared against a field decoder built from the frame layout.
module tb_param_loader;

  localparam int         TMO  = 64;
  localparam logic [7:0] SYNC = 8'hAA;

  typedef struct {
    int unsigned per, p1wid, del, p2wid, nut_w, nut_d, cp, p_bl, p_bl_hf, bl;
  } params_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [31:0] per;
  logic [15:0] p1wid, del, p2wid, nut_d, p_bl_hf;
  logic [7:0]  nut_w, cp, p_bl;
  logic        bl, rx_done, frame_err, tmo_err, busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] pl [18];
  params_t    exp_p;
  params_t    defaults;

  always #10 clk = ~clk;

  param_loader #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid), .nut_w(nut_w),
    .nut_d(nut_d), .cp(cp), .p_bl(p_bl), .p_bl_hf(p_bl_hf), .bl(bl),
    .rx_done(rx_done), .frame_err(frame_err), .tmo_err(tmo_err), .busy(busy)
  );

  function automatic int unsigned be(input int first, input int len);
    int unsigned v = 0;
    for (int i = 0; i < len; i++) v = v * 256 + int'(pl[first + i]);
    return v;
  endfunction

  function automatic params_t decode();
    params_t p;
    p.per     = be(0, 4);
    p.p1wid   = be(4, 2);
    p.del     = be(6, 2);
    p.p2wid   = be(8, 2);
    p.nut_w   = be(10, 1);
    p.nut_d   = be(11, 2);
    p.cp      = be(13, 1);
    p.p_bl    = be(14, 1);
    p.p_bl_hf = be(15, 2);
    p.bl      = be(17, 1) % 2;
    return p;
  endfunction

  function automatic logic [7:0] checksum();
    int s = 0;
    for (int i = 0; i < 18; i++) s += int'(pl[i]);
    return 8'(s % 256);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_params(input string tag);
    check({tag, ".per"},     per,     exp_p.per);
    check({tag, ".p1wid"},   p1wid,   exp_p.p1wid);
    check({tag, ".del"},     del,     exp_p.del);
    check({tag, ".p2wid"},   p2wid,   exp_p.p2wid);
    check({tag, ".nut_w"},   nut_w,   exp_p.nut_w);
    check({tag, ".nut_d"},   nut_d,   exp_p.nut_d);
    check({tag, ".cp"},      cp,      exp_p.cp);
    check({tag, ".p_bl"},    p_bl,    exp_p.p_bl);
    check({tag, ".p_bl_hf"}, p_bl_hf, exp_p.p_bl_hf);
    check({tag, ".bl"},      bl,      exp_p.bl);
  endtask

  task automatic check_strobes(input string tag, input logic done, input logic ferr,
                               input logic terr, input logic bsy);
    check({tag, ".rx_done"},   rx_done,   done);
    check({tag, ".frame_err"}, frame_err, ferr);
    check({tag, ".tmo_err"},   tmo_err,   terr);
    check({tag, ".busy"},      busy,      bsy);
  endtask

  // Called on a falling edge; returns on the falling edge after the byte was sampled.
  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic randomize_payload();
    for (int i = 0; i < 18; i++) pl[i] = 8'($urandom);
  endtask

  task automatic send_frame(input string tag, input bit bad, input int gap_min, input int gap_max);
    logic [7:0] cks;
    send_byte(SYNC);
    check({tag, ".busy_after_sync"}, busy, 1'b1);
    for (int i = 0; i < 18; i++) begin
      idle(int'($urandom_range(gap_max, gap_min)));
      send_byte(pl[i]);
    end
    idle(int'($urandom_range(gap_max, gap_min)));
    check({tag, ".busy_before_cks"}, busy, 1'b1);
    cks = checksum();
    send_byte(bad ? cks + 8'd1 : cks);
    if (!bad) exp_p = decode();
    check_strobes(tag, !bad, bad, 1'b0, 1'b0);
    check_params(tag);
  endtask

  initial begin
    defaults = '{per: 4000, p1wid: 30, del: 200, p2wid: 60, nut_w: 0,
                 nut_d: 0, cp: 1, p_bl: 100, p_bl_hf: 50, bl: 1};
    exp_p    = defaults;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    idle(2);
    check_params("reset_held");
    check_strobes("reset_held", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    idle(1);
    check_params("after_reset");

    $display("[TB] datasheet frame");
    pl = '{8'h00, 8'h00, 8'h13, 8'h88, 8'h00, 8'h28, 8'h00, 8'hC8, 8'h00,
           8'h3C, 8'h05, 8'h00, 8'h0A, 8'h03, 8'h64, 8'h00, 8'h32, 8'h01};
    send_frame("spec", 1'b0, 0, 0);
    check("spec.per_const", per, 32'd5000);
    check("spec.p1wid_const", p1wid, 32'd40);
    check("spec.nut_w_const", nut_w, 32'd5);
    check("spec.nut_d_const", nut_d, 32'd10);
    check("spec.cp_const", cp, 32'd3);
    idle(1);
    check("spec.rx_done_drops", rx_done, 1'b0);

    $display("[TB] bad checksum");
    pl[0] = 8'h01;
    send_frame("badcks", 1'b1, 0, 2);
    idle(1);
    check("badcks.frame_err_drops", frame_err, 1'b0);
    check_params("badcks_after");

    $display("[TB] inter-byte timeout");
    randomize_payload();
    send_byte(SYNC);
    for (int i = 0; i < 7; i++) send_byte(pl[i]);
    idle(TMO - 1);
    check_strobes("tmo_edge_minus1", 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    check_strobes("tmo_fire", 1'b0, 1'b0, 1'b1, 1'b0);
    check_params("tmo_fire");
    idle(1);
    check("tmo.tmo_err_drops", tmo_err, 1'b0);
    randomize_payload();
    send_frame("after_tmo", 1'b0, 0, 3);

    $display("[TB] gaps one short of timeout");
    randomize_payload();
    send_frame("gap_boundary", 1'b0, TMO - 1, TMO - 1);

    $display("[TB] garbage before sync and sync-valued payload");
    idle(1);
    send_byte(8'h55);
    send_byte(8'h12);
    check_strobes("garbage", 1'b0, 1'b0, 1'b0, 1'b0);
    randomize_payload();
    pl[0] = SYNC; pl[5] = SYNC; pl[13] = SYNC; pl[17] = SYNC;
    send_frame("sync_in_payload", 1'b0, 0, 2);

    $display("[TB] reset mid-frame");
    randomize_payload();
    send_byte(SYNC);
    for (int i = 0; i < 10; i++) send_byte(pl[i]);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    exp_p = defaults;
    check_strobes("midreset", 1'b0, 1'b0, 1'b0, 1'b0);
    check_params("midreset");
    randomize_payload();
    send_frame("after_midreset", 1'b0, 0, 2);

    $display("[TB] back-to-back frames");
    randomize_payload();
    send_frame("b2b_1", 1'b0, 0, 0);
    randomize_payload();
    send_frame("b2b_2", 1'b0, 0, 0);

    $display("[TB] random frames");
    for (int n = 0; n < 10; n++) begin
      randomize_payload();
      send_frame($sformatf("rnd%0d", n), ($urandom_range(3, 0) == 0), 0, 4);
    end

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
